// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator producing oversample, mid-bit and end-of-bit ticks.
// Define BAUD_GEN_FRAC_EN to include the fractional phase accumulator and dvsr_frac path.

module baud_gen_frac #(
    parameter int unsigned      CNT_W    = 16,
    parameter int unsigned      FRAC_W   = 4,
    parameter int unsigned      OSR      = 16,
    parameter logic [CNT_W-1:0] DEF_DVSR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_en,
    input  logic [CNT_W-1:0]  dvsr_int,
    input  logic [FRAC_W-1:0] dvsr_frac,
    input  logic              dvsr_load,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_pending
);

    localparam int unsigned     OS_W    = $clog2(OSR);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR / 2 - 1);

    // One extra bit so the stretched period at an all-ones divisor still terminates.
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [CNT_W:0]   limit;
    logic [CNT_W-1:0] act_int_q, act_int_d;
    logic [CNT_W-1:0] shd_int_q, shd_int_d;
    logic             pending_q, pending_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             extra;
    logic             boundary;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              extra_q, extra_d;

    assign extra = extra_q;
`else
    logic unused_frac;

    assign unused_frac = ^dvsr_frac;
    assign extra       = 1'b0;
`endif

    assign limit    = {1'b0, act_int_q} + {{CNT_W{1'b0}}, extra};
    assign boundary = baud_en && !resync && (cnt_q == limit);

    always_comb begin
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        act_int_d  = act_int_q;
        shd_int_d  = shd_int_q;
        pending_d  = pending_q;
`ifdef BAUD_GEN_FRAC_EN
        acc_d      = acc_q;
        extra_d    = extra_q;
        act_frac_d = act_frac_q;
        shd_frac_d = shd_frac_q;
`endif

        if (resync) begin
            cnt_d    = '0;
            os_cnt_d = '0;
`ifdef BAUD_GEN_FRAC_EN
            acc_d    = '0;
            extra_d  = 1'b0;
`endif
        end else if (baud_en) begin
            if (boundary) begin
                cnt_d      = '0;
                os_tick_d  = 1'b1;
                mid_tick_d = (os_cnt_q == OS_MID);
                bit_tick_d = (os_cnt_q == OS_LAST);
                os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
`ifdef BAUD_GEN_FRAC_EN
                {extra_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
`endif
            end else begin
                cnt_d = cnt_q + (CNT_W + 1)'(1);
            end
        end

        // A load landing on an apply edge bypasses the shadow so it governs the next period.
        if (dvsr_load && (boundary || resync)) begin
            act_int_d  = dvsr_int;
            shd_int_d  = dvsr_int;
            pending_d  = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            act_frac_d = dvsr_frac;
            shd_frac_d = dvsr_frac;
`endif
        end else if (dvsr_load) begin
            shd_int_d  = dvsr_int;
            pending_d  = 1'b1;
`ifdef BAUD_GEN_FRAC_EN
            shd_frac_d = dvsr_frac;
`endif
        end else if (pending_q && (boundary || resync || !baud_en)) begin
            act_int_d  = shd_int_q;
            pending_d  = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            act_frac_d = shd_frac_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            act_int_q  <= DEF_DVSR;
            shd_int_q  <= '0;
            pending_q  <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            acc_q      <= '0;
            extra_q    <= 1'b0;
            act_frac_q <= '0;
            shd_frac_q <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            act_int_q  <= act_int_d;
            shd_int_q  <= shd_int_d;
            pending_q  <= pending_d;
`ifdef BAUD_GEN_FRAC_EN
            acc_q      <= acc_d;
            extra_q    <= extra_d;
            act_frac_q <= act_frac_d;
            shd_frac_q <= shd_frac_d;
`endif
        end
    end

    assign os_tick     = os_tick_q;
    assign mid_tick    = mid_tick_q;
    assign bit_tick    = bit_tick_q;
    assign cfg_pending = pending_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed scenarios plus randomized runs
// against an arithmetic period-schedule model.

module tb_baud_gen_frac;

    localparam int CNT_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;
`ifdef BAUD_GEN_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              baud_en = 1'b0;
    logic [CNT_W-1:0]  dvsr_int = '0;
    logic [FRAC_W-1:0] dvsr_frac = '0;
    logic              dvsr_load = 1'b0;
    logic              resync = 1'b0;
    logic              os_tick, mid_tick, bit_tick, cfg_pending;

    int n_checks = 0;
    int n_pass   = 0;

    baud_gen_frac #(
        .CNT_W   (CNT_W),
        .FRAC_W  (FRAC_W),
        .OSR     (OSR),
        .DEF_DVSR(16'd0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_en    (baud_en),
        .dvsr_int   (dvsr_int),
        .dvsr_frac  (dvsr_frac),
        .dvsr_load  (dvsr_load),
        .resync     (resync),
        .os_tick    (os_tick),
        .mid_tick   (mid_tick),
        .bit_tick   (bit_tick),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    // Extra clock of period n (n counted from the last phase restart) from the running
    // fractional sum: floor(n*f/2^F) - floor((n-1)*f/2^F).
    function automatic int extra_of(input int n, input int frac);
        if (!FRAC_ON || n == 0) return 0;
        return (n * frac) / (1 << FRAC_W) - ((n - 1) * frac) / (1 << FRAC_W);
    endfunction

    // All tasks start and end just after a falling edge; inputs set here hit the next rise.
    task automatic step(input logic en);
        baud_en = en;
        @(negedge clk);
    endtask

    task automatic configure(input int di, input int df);
        baud_en   = 1'b0;
        dvsr_load = 1'b1;
        dvsr_int  = CNT_W'(di);
        dvsr_frac = FRAC_W'(df);
        @(negedge clk);
        n_checks++;
        if (cfg_pending !== 1'b1) $display("FAIL cfg_load_pending got=%b exp=1", cfg_pending);
        else n_pass++;
        dvsr_load = 1'b0;
        resync    = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        n_checks++;
        if ({os_tick, mid_tick, bit_tick, cfg_pending} !== 4'b0)
            $display("FAIL cfg_resync_clear got=%b exp=0000",
                     {os_tick, mid_tick, bit_tick, cfg_pending});
        else n_pass++;
    endtask

    // Drives baud_en (en_pct % high) and compares every tick against the period schedule.
    task automatic run_model(input string tag, input int di, input int df, input int cycles,
                             input int en_pct);
        int   en_cnt = 0;
        int   k      = 0;
        int   target = di + 1;
        logic en;
        logic [2:0] exp_t;
        for (int c = 1; c <= cycles; c++) begin
            en    = ($urandom_range(99) < en_pct);
            exp_t = 3'b000;
            step(en);
            if (en) begin
                en_cnt++;
                if (en_cnt == target) begin
                    exp_t = {1'b1, (k % OSR) == (OSR / 2 - 1), (k % OSR) == (OSR - 1)};
                    k++;
                    target += di + 1 + extra_of(k, df);
                end
            end
            n_checks++;
            if ({os_tick, mid_tick, bit_tick} !== exp_t)
                $display("FAIL %s cyc=%0d di=%0d df=%0d ticks got=%b exp=%b",
                         tag, c, di, df, {os_tick, mid_tick, bit_tick}, exp_t);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({os_tick, mid_tick, bit_tick, cfg_pending} !== 4'b0)
            $display("FAIL reset_state got=%b exp=0000",
                     {os_tick, mid_tick, bit_tick, cfg_pending});
        else n_pass++;
        rst_n = 1'b1;
        // Default divisor 0: a tick every enabled cycle, mid on the 8th, bit on the 16th.
        for (int c = 1; c <= 48; c++) begin
            step(1'b1);
            n_checks++;
            if ({os_tick, mid_tick, bit_tick} !== {1'b1, (c % 16) == 8, (c % 16) == 0})
                $display("FAIL reset_def_dvsr cyc=%0d got=%b exp=%b", c,
                         {os_tick, mid_tick, bit_tick}, {1'b1, (c % 16) == 8, (c % 16) == 0});
            else n_pass++;
        end
    endtask

    task automatic test_int_div();
        configure(3, 0);
        run_model("int_div", 3, 0, 140, 100);
    endtask

    task automatic test_frac();
        int times[$];
        int fives = 0;
        int d;
        configure(3, 4);
        for (int c = 1; c <= 200 && times.size() < 17; c++) begin
            step(1'b1);
            if (os_tick) times.push_back(c);
        end
        n_checks++;
        if (times.size() != 17) begin
            $display("FAIL frac_tick_count got=%0d exp=17", times.size());
        end else begin
            n_pass++;
            for (int j = 1; j <= 16; j++) begin
                d = times[j] - times[j-1];
                if (d == 5) fives++;
                n_checks++;
                if (d != ((FRAC_ON && (j % 4 == 0)) ? 5 : 4))
                    $display("FAIL frac_period n=%0d got=%0d exp=%0d", j, d,
                             (FRAC_ON && (j % 4 == 0)) ? 5 : 4);
                else n_pass++;
            end
            n_checks++;
            if (times[16] - times[0] != (FRAC_ON ? 68 : 64))
                $display("FAIL frac_16_periods got=%0d exp=%0d", times[16] - times[0],
                         FRAC_ON ? 68 : 64);
            else n_pass++;
            n_checks++;
            if (fives != (FRAC_ON ? 4 : 0))
                $display("FAIL frac_long_count got=%0d exp=%0d", fives, FRAC_ON ? 4 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_gap();
        int got = 0;
        configure(3, 0);
        for (int c = 1; c <= 12; c++) begin
            step(c <= 2);
            n_checks++;
            if ({os_tick, mid_tick, bit_tick} !== 3'b000)
                $display("FAIL gap_quiet cyc=%0d got=%b exp=000", c,
                         {os_tick, mid_tick, bit_tick});
            else n_pass++;
        end
        for (int c = 13; c <= 24; c++) begin
            step(1'b1);
            if (os_tick) begin
                got = c;
                break;
            end
        end
        n_checks++;
        if (got != 14) $display("FAIL gap_resume got=%0d exp=14", got);
        else n_pass++;
    endtask

    task automatic test_resync();
        int got_mid = 0;
        int n_os    = 0;
        int n_bit   = 0;
        configure(3, 0);
        // 23 enabled edges: boundaries at 4..20 leave os_cnt=5, edge 24 would be a boundary.
        for (int c = 1; c <= 23; c++) step(1'b1);
        resync = 1'b1;
        step(1'b1);
        resync = 1'b0;
        n_checks++;
        if ({os_tick, mid_tick, bit_tick} !== 3'b000)
            $display("FAIL resync_prio got=%b exp=000", {os_tick, mid_tick, bit_tick});
        else n_pass++;
        for (int c = 1; c <= 64; c++) begin
            step(1'b1);
            if (os_tick) n_os++;
            if (bit_tick) n_bit++;
            if (mid_tick) begin
                got_mid = c;
                break;
            end
        end
        n_checks++;
        if (got_mid != 32) $display("FAIL resync_mid_delay got=%0d exp=32", got_mid);
        else n_pass++;
        n_checks++;
        if (n_os != 8 || n_bit != 0)
            $display("FAIL resync_os_count got=%0d/%0d exp=8/0", n_os, n_bit);
        else n_pass++;
    endtask

    task automatic test_pending();
        int got = 0;
        configure(3, 0);
        step(1'b1);
        dvsr_load = 1'b1;
        dvsr_int  = 16'd7;
        step(1'b1);
        n_checks++;
        if (cfg_pending !== 1'b1) $display("FAIL pend_set got=%b exp=1", cfg_pending);
        else n_pass++;
        dvsr_int = 16'd9;
        step(1'b1);
        dvsr_load = 1'b0;
        n_checks++;
        if ({os_tick, cfg_pending} !== 2'b01)
            $display("FAIL pend_hold got=%b exp=01", {os_tick, cfg_pending});
        else n_pass++;
        step(1'b1);
        n_checks++;
        if ({os_tick, cfg_pending} !== 2'b10)
            $display("FAIL pend_apply got=%b exp=10", {os_tick, cfg_pending});
        else n_pass++;
        for (int c = 1; c <= 20; c++) begin
            step(1'b1);
            if (os_tick) begin
                got = c;
                break;
            end
        end
        n_checks++;
        if (got != 10) $display("FAIL pend_last_wins got=%0d exp=10", got);
        else n_pass++;
        // Load coincident with the boundary takes effect for the very next period.
        for (int c = 1; c <= 9; c++) step(1'b1);
        dvsr_load = 1'b1;
        dvsr_int  = 16'd1;
        step(1'b1);
        dvsr_load = 1'b0;
        n_checks++;
        if ({os_tick, cfg_pending} !== 2'b10)
            $display("FAIL pend_bypass got=%b exp=10", {os_tick, cfg_pending});
        else n_pass++;
        got = 0;
        for (int c = 1; c <= 8; c++) begin
            step(1'b1);
            if (os_tick) begin
                got = c;
                break;
            end
        end
        n_checks++;
        if (got != 2) $display("FAIL pend_bypass_period got=%0d exp=2", got);
        else n_pass++;
        // Leave a pending load in place, then reset mid-period.
        dvsr_load = 1'b1;
        dvsr_int  = 16'd5;
        step(1'b1);
        dvsr_load = 1'b0;
        n_checks++;
        if (cfg_pending !== 1'b1) $display("FAIL pend_pre_reset got=%b exp=1", cfg_pending);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({os_tick, mid_tick, bit_tick, cfg_pending} !== 4'b0)
            $display("FAIL reset_mid got=%b exp=0000",
                     {os_tick, mid_tick, bit_tick, cfg_pending});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step(1'b1);
            n_checks++;
            if ({os_tick, cfg_pending} !== 2'b10)
                $display("FAIL reset_recover cyc=%0d got=%b exp=10", c, {os_tick, cfg_pending});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int di, df, pct;
        for (int it = 0; it < 8; it++) begin
            di  = $urandom_range(6);
            df  = $urandom_range(15);
            pct = $urandom_range(100, 60);
            configure(di, df);
            run_model("random", di, df, 200, pct);
        end
    endtask

    initial begin
        test_reset();
        test_int_div();
        test_frac();
        test_gap();
        test_resync();
        test_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter CNT_W, default 16: width of integer divisor and period counter.
REQ-002 Parameter FRAC_W, default 4: width of fractional divisor and phase accumulator.
REQ-003 Parameter OSR, default 16: oversample ticks per bit; must be an even number, at least 4.
REQ-004 Parameter DEF_DVSR, default 16'd0: reset value of the active integer divisor.
REQ-005 Port clk, in, 1: single clock; all logic is posedge clk.
REQ-006 Port rst_n, in, 1: asynchronous, active-low reset.
REQ-007 Port baud_en, in, 1: count enable.
REQ-008 Port dvsr_int, in, CNT_W: integer divisor; one os period is dvsr_int+1 clocks.
REQ-009 Port dvsr_frac, in, FRAC_W: fractional divisor, in units of 1/2^FRAC_W clock.
REQ-010 Port dvsr_load, in, 1: one-cycle strobe that captures dvsr_int and dvsr_frac into shadow registers.
REQ-011 Port resync, in, 1: phase restart strobe, used on an RX start-bit edge.
REQ-012 Port os_tick, out, 1: registered one-cycle oversample tick.
REQ-013 Port mid_tick, out, 1: registered one-cycle tick at mid-bit.
REQ-014 Port bit_tick, out, 1: registered one-cycle tick at end of bit.
REQ-015 Port cfg_pending, out, 1: high while a shadow divisor is waiting to be applied.

Function
REQ-016 On each enabled cycle, if cnt==limit: cnt<=0 and os_tick<=1; otherwise cnt<=cnt+1 and os_tick<=0.
REQ-017 limit = act_int + extra, computed in CNT_W+1 bits so there is no overflow at act_int = all-ones.
REQ-018 At each os boundary (cnt==limit while enabled), the block computes {carry,acc} <= acc + act_frac, and extra <= carry for the next period.
REQ-019 Average os period = act_int + 1 + act_frac/2^FRAC_W clocks; the error accumulated over 2^FRAC_W periods is exactly zero.
REQ-020 os_cnt counts os boundaries from 0 to OSR-1 and then wraps to 0.
REQ-021 bit_tick <= 1 on the os boundary where os_cnt==OSR-1; it is coincident with os_tick.
REQ-022 mid_tick <= 1 on the os boundary where os_cnt==OSR/2-1; it is coincident with os_tick.
REQ-023 When baud_en is low: cnt, acc, extra and os_cnt hold; all tick outputs are 0 on the next cycle.
REQ-024 When act_int==0 and extra==0: os_tick stays continuously high while enabled.
REQ-025 dvsr_load sets the shadow registers and cfg_pending<=1.
REQ-026 The shadow values are applied to act_int/act_frac at the next os boundary, or on the next clock edge if baud_en is low; cfg_pending<=0 at the same edge.
REQ-027 If dvsr_load coincides with an os boundary, the new value governs the immediately following period.
REQ-028 A second dvsr_load before the shadow is applied overwrites the shadow; the last value wins.
REQ-029 resync clears cnt, acc, extra and os_cnt, and forces all ticks to 0 on the next edge.
REQ-030 resync has priority over baud_en and over the os boundary; a pending shadow is applied at the resync edge.
REQ-031 After resync, the first mid_tick arrives OSR/2 os periods later.

Reset
REQ-032 When rst_n is low: cnt, acc, extra, os_cnt, shadow and cfg_pending clear to 0; act_int=DEF_DVSR; act_frac=0; os_tick, mid_tick and bit_tick are 0.
REQ-033 Reset asserted mid-period aborts that period immediately; no tick is produced.
REQ-034 After rst_n deasserts, counting starts at the first enabled edge.

Configuration
REQ-035 Macro BAUD_GEN_FRAC_EN defined: the fractional accumulator, dvsr_frac path and extra logic are present, per REQ-017 to REQ-019.
REQ-036 Macro BAUD_GEN_FRAC_EN undefined: dvsr_frac is ignored, acc and extra are absent and extra is treated as 0, so os period = act_int+1 exactly; all other behaviour is unchanged.

Verification
REQ-037 rst_n low then high, baud_en=1, DEF_DVSR=0 -> os_tick high every cycle; bit_tick every 16 cycles; mid_tick 8 cycles before each bit_tick.
REQ-038 Load dvsr_int=3, dvsr_frac=0, OSR=16 -> os_tick period 4 clocks; bit_tick period 64 clocks; cfg_pending clears at the first boundary.
REQ-039 Load dvsr_int=3, dvsr_frac=4 with FRAC_W=4 -> 16 consecutive os periods total 68 clocks; periods of 5 clocks occur every 4th period. With the macro undefined -> exactly 64 clocks.
REQ-040 baud_en dropped for 10 cycles mid-period with dvsr_int=3 -> no ticks during the gap; the period resumes from the held cnt, so total elapsed time = 4+10 clocks.
REQ-041 resync pulse while os_cnt=5 and dvsr_int=3 -> ticks 0 on the next edge; the first mid_tick occurs 8 os periods (32 clocks) after resync.
REQ-042 dvsr_load of 7 then 9 before a boundary, and rst_n pulsed low mid-period -> only 9 is applied; after reset act_int=DEF_DVSR and all outputs are 0.
